ccip_c0_rd_arbiter: RTL and testbench
=====================================

Name: ccip_c0_rd_arbiter

Overview:
- Shares the CCI-P C0 read-request channel of the AFU clock domain among NUM_REQ requester engines, e.g. multiple NLB-style engines behind the async shim.
- Round-robin arbitration, honours c0 almost-full, tracks outstanding reads against a credit limit, and tags mdata so read responses route back to the issuing requester.
- Provides a quiesce handshake so the AFU can be drained before soft reset or reconfiguration.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_OUTSTANDING, 64, maximum reads in flight across all requesters (1..255)
ADDR_W, 42, cache-line address width

Ports:
afu_clk  in  1  AFU clock
afu_softreset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_W  per-requester line address, requester i at [i*ADDR_W +: ADDR_W]
req_tag  in  NUM_REQ*12  per-requester 12-bit tag
req_grant  out  NUM_REQ  one-hot accept pulse; request consumed this cycle
c0_almfull  in  1  C0 Tx almost-full from shim
c0_tx_valid  out  1  read request to shim
c0_tx_addr  out  ADDR_W  request address
c0_tx_mdata  out  16  {requester id[3:0], tag[11:0]}
c0_rx_rdvalid  in  1  read response valid
c0_rx_mdata  in  16  response mdata
c0_rx_data  in  512  response data
rsp_valid  out  NUM_REQ  one-hot response strobe
rsp_tag  out  12  returned tag
rsp_data  out  512  returned line
quiesce  in  1  stop issuing and drain
quiesced  out  1  no reads in flight, issue stopped
outstanding  out  8  reads in flight
err_bad_id  out  1  sticky: response id >= NUM_REQ

Behaviour:
- Reset (async assert, sync release): all outputs 0, rr pointer = 0, outstanding = 0, state RUN.
- Issue is eligible when: state == RUN, c0_almfull == 0, outstanding < MAX_OUTSTANDING, and any req_valid.
- Grant selection: first requester at or after rr pointer (wrapping), combinational req_grant. rr pointer advances to winner+1 (mod NUM_REQ) on grant.
- Issue latency: granted request appears on c0_tx_valid/addr/mdata the next cycle, registered. c0_tx_valid is a single-cycle pulse per grant; back-to-back grants are allowed every cycle.
- c0_almfull takes effect in the same cycle: no grant while it is high. Requests already registered still issue; the shim absorbs them within its almost-full slack.
- Response path: on c0_rx_rdvalid, id = c0_rx_mdata[15:12].
  - Valid id: next cycle rsp_valid[id] = 1, rsp_tag = mdata[11:0], rsp_data registered.
  - id >= NUM_REQ: no rsp_valid; err_bad_id set until reset. Outstanding still decrements.
- Outstanding counter:
  - +1 when c0_tx_valid is high.
  - -1 on c0_rx_rdvalid.
  - Both in the same cycle: unchanged.
  - Saturates at 0: a response with counter == 0 leaves it at 0 and sets err_bad_id.
- FSM:
  - RUN -> DRAIN when quiesce = 1. No new grants; a registered in-flight request still issues.
  - DRAIN -> QUIESCED when outstanding == 0 and c0_tx_valid == 0.
  - QUIESCED: quiesced = 1 (registered). Returns to RUN on quiesce = 0, with quiesced dropping the same cycle as the transition.
  - DRAIN -> RUN directly if quiesce drops before empty.
- Reset mid-operation clears counters. Responses arriving after reset with counter 0 follow the saturation rule.

Decomposition:
- Shared package ccip_arb_pkg: mdata field positions (ID_MSB = 15, ID_LSB = 12, TAG_W = 12), t_arb_state enum {RUN, DRAIN, QUIESCED}, max requester count 16.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin priority select with pointer update), reusable later for C1 writes.

Test Plan:
- All 4 req_valid held high, almfull = 0: grants cycle 0,1,2,3,0. c0_tx_mdata[15:12] follows 0,1,2,3 one cycle after each grant; outstanding reaches 5 after 5 issues.
- Set MAX_OUTSTANDING = 4, no responses: exactly 4 grants, then req_grant stays 0. One response with mdata = 0x2ABC -> rsp_valid[2] = 1, rsp_tag = 0xABC next cycle, one further grant follows.
- c0_almfull asserted for 10 cycles with req_valid[1] high: zero grants during those cycles; grant in the cycle almfull deasserts.
- Same cycle issue + response with outstanding = 3: outstanding stays 3.
- Response with mdata = 0x7001 and NUM_REQ = 4: no rsp_valid, err_bad_id = 1, outstanding decrements by 1.
- quiesce with 3 outstanding: DRAIN, no grants. Return 3 responses -> quiesced = 1 the cycle after outstanding hits 0. Deassert quiesce -> grants resume. Assert afu_softreset_n low mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/ccip_arb_pkg.sv
// ccip_arb_pkg: shared mdata layout and arbiter state encoding for the CCI-P request arbiters.
package ccip_arb_pkg;
  localparam int ID_MSB  = 15;
  localparam int ID_LSB  = 12;
  localparam int ID_W    = ID_MSB - ID_LSB + 1;
  localparam int TAG_W   = 12;
  localparam int MAX_REQ = 16;
  typedef enum logic [1:0] {RUN, DRAIN, QUIESCED} t_arb_state;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin select of the first request at or after the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);
  logic [PW-1:0]  r_ptr;
  logic [2*N-1:0] w_dbl;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;
  logic           w_found;
  // Rotating a doubled request vector turns the wrap-around search into a plain priority scan.
  always_comb begin
    w_dbl   = {i_req, i_req} >> r_ptr;
    w_off   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_dbl[k]) begin
        w_found = 1'b1;
        w_off   = PW'(k);
      end
    end
    w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
    o_idx   = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : PW'(w_sum);
    o_grant = (i_en && w_found) ? N'(1) << o_idx : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ptr <= '0;
    else if (|o_grant) r_ptr <= (o_idx == PW'(N-1)) ? '0 : o_idx + PW'(1);
  end
endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// ccip_c0_rd_arbiter: shares the CCI-P C0 read channel among requesters with credits,
// mdata-based response routing and a quiesce/drain handshake.
module ccip_c0_rd_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W          = 42
) (
  input  logic                      i_afu_clk,
  input  logic                      i_afu_softreset_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*12-1:0]     i_req_tag,
  output logic [NUM_REQ-1:0]        o_req_grant,
  input  logic                      i_c0_almfull,
  output logic                      o_c0_tx_valid,
  output logic [ADDR_W-1:0]         o_c0_tx_addr,
  output logic [15:0]               o_c0_tx_mdata,
  input  logic                      i_c0_rx_rdvalid,
  input  logic [15:0]               i_c0_rx_mdata,
  input  logic [511:0]              i_c0_rx_data,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [11:0]               o_rsp_tag,
  output logic [511:0]              o_rsp_data,
  input  logic                      i_quiesce,
  output logic                      o_quiesced,
  output logic [7:0]                o_outstanding,
  output logic                      o_err_bad_id
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  t_arb_state        r_state;
  logic              w_elig;
  logic [PW-1:0]     w_idx;
  logic [ID_W-1:0]   w_rx_id;
  logic              w_id_ok;
  // The request registered for issue already holds a credit, so it counts against the limit.
  assign w_elig  = i_afu_softreset_n && r_state == RUN && !i_c0_almfull &&
                   ({1'b0, o_outstanding} + 9'(o_c0_tx_valid) < 9'(MAX_OUTSTANDING));
  assign w_rx_id = i_c0_rx_mdata[ID_MSB:ID_LSB];
  assign w_id_ok = {1'b0, w_rx_id} < (ID_W+1)'(NUM_REQ);
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_clk   (i_afu_clk),
    .i_rst_n (i_afu_softreset_n),
    .i_en    (w_elig),
    .i_req   (i_req_valid),
    .o_grant (o_req_grant),
    .o_idx   (w_idx)
  );
  always_ff @(posedge i_afu_clk or negedge i_afu_softreset_n) begin
    if (!i_afu_softreset_n) begin
      o_c0_tx_valid <= 1'b0;
      o_c0_tx_addr  <= '0;
      o_c0_tx_mdata <= '0;
      o_rsp_valid   <= '0;
      o_rsp_tag     <= '0;
      o_rsp_data    <= '0;
      o_outstanding <= '0;
      o_err_bad_id  <= 1'b0;
    end else begin
      o_c0_tx_valid <= |o_req_grant;
      if (|o_req_grant) begin
        o_c0_tx_addr  <= i_req_addr[w_idx*ADDR_W +: ADDR_W];
        o_c0_tx_mdata <= {ID_W'(w_idx), i_req_tag[w_idx*TAG_W +: TAG_W]};
      end
      o_rsp_valid <= (i_c0_rx_rdvalid && w_id_ok) ? NUM_REQ'(1) << w_rx_id : '0;
      if (i_c0_rx_rdvalid) begin
        o_rsp_tag  <= i_c0_rx_mdata[TAG_W-1:0];
        o_rsp_data <= i_c0_rx_data;
      end
      // A response with nothing in flight is unaccounted for: hold the count at zero and flag it.
      if (i_c0_rx_rdvalid && (!w_id_ok || (o_outstanding == '0 && !o_c0_tx_valid))) o_err_bad_id <= 1'b1;
      o_outstanding <= o_outstanding + 8'(o_c0_tx_valid)
                     - 8'(i_c0_rx_rdvalid && (o_outstanding != '0 || o_c0_tx_valid));
    end
  end
  always_ff @(posedge i_afu_clk or negedge i_afu_softreset_n) begin
    if (!i_afu_softreset_n) begin
      r_state    <= RUN;
      o_quiesced <= 1'b0;
    end else begin
      case (r_state)
        RUN:      if (i_quiesce) r_state <= DRAIN;
        DRAIN:    if (!i_quiesce) r_state <= RUN;
                  else if (o_outstanding == '0 && !o_c0_tx_valid) begin
                    r_state    <= QUIESCED;
                    o_quiesced <= 1'b1;
                  end
        QUIESCED: if (!i_quiesce) begin
                    r_state    <= RUN;
                    o_quiesced <= 1'b0;
                  end
        default:  r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// tb_ccip_c0_rd_arbiter: table-driven cycle vectors plus hand sequences for drain/reset, saturation and credit limit.
module tb_ccip_c0_rd_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0]   rv = '0;
  logic [167:0] req_addr;
  logic [47:0]  req_tag;
  logic         af = 1'b0, rd = 1'b0, q = 1'b0;
  logic [15:0]  rdm = '0;
  logic [511:0] rx_data = '0;
  logic [3:0]   grant, rsp, l_grant, l_rsp;
  logic         txv, qd, err, l_txv, l_qd, l_err;
  logic [41:0]  tx_addr, l_tx_addr;
  logic [15:0]  tx_md, l_tx_md;
  logic [11:0]  tag, l_tag;
  logic [511:0] rdata, l_rdata;
  logic [7:0]   outs, l_outs;
  logic [41:0]  a_addr [4];
  ccip_c0_rd_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(64), .ADDR_W(42)) u_dut (
    .i_afu_clk(clk), .i_afu_softreset_n(rst_n), .i_req_valid(rv), .i_req_addr(req_addr),
    .i_req_tag(req_tag), .o_req_grant(grant), .i_c0_almfull(af), .o_c0_tx_valid(txv),
    .o_c0_tx_addr(tx_addr), .o_c0_tx_mdata(tx_md), .i_c0_rx_rdvalid(rd), .i_c0_rx_mdata(rdm),
    .i_c0_rx_data(rx_data), .o_rsp_valid(rsp), .o_rsp_tag(tag), .o_rsp_data(rdata),
    .i_quiesce(q), .o_quiesced(qd), .o_outstanding(outs), .o_err_bad_id(err));
  ccip_c0_rd_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(4), .ADDR_W(42)) u_lim (
    .i_afu_clk(clk), .i_afu_softreset_n(rst_n), .i_req_valid(rv), .i_req_addr(req_addr),
    .i_req_tag(req_tag), .o_req_grant(l_grant), .i_c0_almfull(af), .o_c0_tx_valid(l_txv),
    .o_c0_tx_addr(l_tx_addr), .o_c0_tx_mdata(l_tx_md), .i_c0_rx_rdvalid(rd), .i_c0_rx_mdata(rdm),
    .i_c0_rx_data(rx_data), .o_rsp_valid(l_rsp), .o_rsp_tag(l_tag), .o_rsp_data(l_rdata),
    .i_quiesce(q), .o_quiesced(l_qd), .o_outstanding(l_outs), .o_err_bad_id(l_err));
  typedef struct {
    logic [3:0] rv; logic af; logic rd; logic [15:0] rdm; logic q;
    logic [3:0] g; logic txv; logic [15:0] md; logic [7:0] o; logic [3:0] rsp; logic [11:0] tag; logic er; logic qd;
  } vec_t;
  vec_t tbl [$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(logic [3:0] rv_, logic af_, logic rd_, logic [15:0] rdm_, logic q_,
      logic [3:0] g_, logic txv_, logic [15:0] md_, logic [7:0] o_, logic [3:0] rsp_, logic [11:0] tag_,
      logic er_, logic qd_);
    vec_t v;
    v.rv = rv_; v.af = af_; v.rd = rd_; v.rdm = rdm_; v.q = q_;
    v.g = g_; v.txv = txv_; v.md = md_; v.o = o_; v.rsp = rsp_; v.tag = tag_; v.er = er_; v.qd = qd_;
    return v;
  endfunction
  initial begin
    int cnt;
    logic [15:0] prev_rdm;
    for (int i = 0; i < 4; i++) begin
      a_addr[i] = 42'h2_0000_0000 + 42'(i) * 42'h1_2345;
      req_addr[i*42 +: 42] = a_addr[i];
      req_tag[i*12 +: 12] = 12'h100 + 12'(i);
    end
    //              rv    af rd  rdm      q   grant txv md       out  rsp   tag     err qd
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 0, 4'h1, 0, 16'h0000, 8'd0, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 0, 4'h2, 1, 16'h0100, 8'd0, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 0, 4'h4, 1, 16'h1101, 8'd1, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 0, 4'h8, 1, 16'h2102, 8'd2, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 0, 4'h1, 1, 16'h3103, 8'd3, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 16'h0000, 0, 4'h0, 1, 16'h0100, 8'd4, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 8'd5, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 16'h1101, 0, 4'h0, 0, 16'h0000, 8'd5, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 16'h0100, 0, 4'h0, 0, 16'h0000, 8'd4, 4'h2, 12'h101, 0, 0));
    tbl.push_back(mk(4'h4, 0, 0, 16'h0000, 0, 4'h4, 0, 16'h0000, 8'd3, 4'h1, 12'h100, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 16'h2102, 0, 4'h0, 1, 16'h2102, 8'd3, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 8'd3, 4'h4, 12'h102, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 16'h7001, 0, 4'h0, 0, 16'h0000, 8'd3, 4'h0, 12'h0,   0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 8'd2, 4'h0, 12'h0,   1, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(4'h2, 1, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 8'd2, 4'h0, 12'h0, 1, 0));
    tbl.push_back(mk(4'h2, 0, 0, 16'h0000, 0, 4'h2, 0, 16'h0000, 8'd2, 4'h0, 12'h0,   1, 0));
    tbl.push_back(mk(4'h0, 0, 0, 16'h0000, 0, 4'h0, 1, 16'h1101, 8'd2, 4'h0, 12'h0,   1, 0));
    tbl.push_back(mk(4'h0, 0, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 8'd3, 4'h0, 12'h0,   1, 0));
    tbl.push_back(mk(4'h0, 0, 0, 16'h0000, 1, 4'h0, 0, 16'h0000, 8'd3, 4'h0, 12'h0,   1, 0));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 1, 4'h0, 0, 16'h0000, 8'd3, 4'h0, 12'h0,   1, 0));
    tbl.push_back(mk(4'hF, 0, 1, 16'h0001, 1, 4'h0, 0, 16'h0000, 8'd3, 4'h0, 12'h0,   1, 0));
    tbl.push_back(mk(4'hF, 0, 1, 16'h1002, 1, 4'h0, 0, 16'h0000, 8'd2, 4'h1, 12'h001, 1, 0));
    tbl.push_back(mk(4'hF, 0, 1, 16'h2003, 1, 4'h0, 0, 16'h0000, 8'd1, 4'h2, 12'h002, 1, 0));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 1, 4'h0, 0, 16'h0000, 8'd0, 4'h4, 12'h003, 1, 0));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 1, 4'h0, 0, 16'h0000, 8'd0, 4'h0, 12'h0,   1, 1));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 8'd0, 4'h0, 12'h0,   1, 1));
    tbl.push_back(mk(4'hF, 0, 0, 16'h0000, 0, 4'h4, 0, 16'h0000, 8'd0, 4'h0, 12'h0,   1, 0));
    // Reset state, with requests present to show grants are held off during reset.
    rv = 4'hF;
    #1;
    chk("rst grant", grant, 4'h0);
    chk("rst txv", txv, 1'b0);
    chk("rst outstanding", outs, 8'd0);
    chk("rst rsp_valid", rsp, 4'h0);
    chk("rst err", err, 1'b0);
    chk("rst quiesced", qd, 1'b0);
    rv = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_rdm = '0;
    foreach (tbl[i]) begin
      @(negedge clk);
      rv = tbl[i].rv; af = tbl[i].af; rd = tbl[i].rd; rdm = tbl[i].rdm; q = tbl[i].q;
      rx_data = {32{tbl[i].rdm}};
      #1;
      chk($sformatf("v%0d grant", i), grant, tbl[i].g);
      chk($sformatf("v%0d txv", i), txv, tbl[i].txv);
      chk($sformatf("v%0d outstanding", i), outs, tbl[i].o);
      chk($sformatf("v%0d rsp_valid", i), rsp, tbl[i].rsp);
      chk($sformatf("v%0d err", i), err, tbl[i].er);
      chk($sformatf("v%0d quiesced", i), qd, tbl[i].qd);
      if (tbl[i].txv) begin
        chk($sformatf("v%0d mdata", i), tx_md, tbl[i].md);
        chk($sformatf("v%0d addr", i), tx_addr, a_addr[tbl[i].md[13:12]]);
      end
      if (tbl[i].rsp != 4'h0) begin
        chk($sformatf("v%0d tag", i), tag, tbl[i].tag);
        chk($sformatf("v%0d data", i), rdata, {32{prev_rdm}});
      end
      prev_rdm = tbl[i].rdm;
    end
    // Drain with one read in flight, then reset mid-drain.
    @(negedge clk); rv = 4'h0; q = 1'b1; rd = 1'b0;
    @(negedge clk); #1;
    chk("drain outstanding", outs, 8'd1);
    @(negedge clk); rv = 4'hF; #1;
    chk("drain no grant", grant, 4'h0);
    chk("drain not quiesced", qd, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("midrst grant", grant, 4'h0);
    chk("midrst txv", txv, 1'b0);
    chk("midrst outstanding", outs, 8'd0);
    chk("midrst err", err, 1'b0);
    chk("midrst tag", tag, 12'h0);
    chk("midrst quiesced", qd, 1'b0);
    // Response with nothing outstanding: count saturates, error flagged, still routed.
    @(negedge clk); rst_n = 1'b1; rv = 4'h0; q = 1'b0; rd = 1'b1; rdm = 16'h0005; rx_data = {32{rdm}};
    @(negedge clk); rd = 1'b0; #1;
    chk("sat outstanding", outs, 8'd0);
    chk("sat err", err, 1'b1);
    chk("sat rsp_valid", rsp, 4'h1);
    // Credit limit of 4 on the second instance.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; rv = 4'hF;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1 cnt += $countones(l_grant);
      @(negedge clk);
    end
    #1;
    chk("credit grant count", 32'(cnt), 32'd4);
    chk("credit outstanding", l_outs, 8'd4);
    chk("credit grant held", l_grant, 4'h0);
    rd = 1'b1; rdm = 16'h2ABC; rx_data = {32{rdm}};
    @(negedge clk); rd = 1'b0; #1;
    chk("credit rsp_valid", l_rsp, 4'h4);
    chk("credit rsp_tag", l_tag, 12'hABC);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cnt += $countones(l_grant);
      @(negedge clk); #1;
    end
    chk("credit regrant count", 32'(cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
